// File: rtl/serial_pkg.sv
// serial_pkg: shared types for the bit-serial operand protocol
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: parallel operand pair to LSB-first vld/a/b/last stream
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [$clog2(W)-1:0] in_last_idx,
  output logic                 vld,
  output logic                 a,
  output logic                 b,
  output logic                 last,
  output logic                 busy
);
  localparam int CW = $clog2(W);
  ser_state_t    r_state, w_next;
  logic [W-1:0]  r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic          w_shift, w_last, w_acc;
  assign w_shift = r_state == SHIFT;
  assign w_last  = w_shift && r_cnt == '0;
  assign in_rdy  = !w_shift || w_last;
  assign w_acc   = in_vld && in_rdy;
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = SHIFT;
    else if (w_last) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_cnt <= in_last_idx;
    end else if (w_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  // residual shift-register bits are masked once the word has drained
  assign vld  = w_shift;
  assign a    = w_shift & r_a[0];
  assign b    = w_shift & r_b[0];
  assign last = w_last;
  assign busy = w_shift;
endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb_serial_operand_serializer: directed checks of the serial operand transmitter
module tb_serial_operand_serializer;
  logic       clk = 0;
  logic       rst = 0;
  logic       in_vld = 0;
  logic       in_rdy;
  logic [7:0] in_a = 0, in_b = 0;
  logic [2:0] in_last_idx = 0;
  logic       vld, a, b, last, busy;
  int         total = 0, bad = 0;
  logic [7:0] ea, eb, sum;
  logic [5:0] ta, tb, tl;
  logic [2:0] pa, pb;
  logic       c;

  serial_operand_serializer #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .in_last_idx(in_last_idx), .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_rdy, 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      tick;
      idle_chk("rst");
    end
    @(negedge clk);
    rst = 1;
    tick;
    idle_chk("post_rst");

    ea = 8'hA5; eb = 8'h3C;
    in_a = ea; in_b = eb; in_last_idx = 7; in_vld = 1;
    chk("full_rdy0", in_rdy, 1);
    tick;
    in_vld = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_vld%0d", k), vld, 1);
      chk($sformatf("full_busy%0d", k), busy, 1);
      chk($sformatf("full_a%0d", k), a, ea[k]);
      chk($sformatf("full_b%0d", k), b, eb[k]);
      chk($sformatf("full_last%0d", k), last, k == 7);
      chk($sformatf("full_rdy%0d", k + 1), in_rdy, k == 7);
      tick;
    end
    idle_chk("full_end");

    pa = 3'b101; pb = 3'b011;
    in_last_idx = 0; in_vld = 1;
    for (int i = 0; i < 3; i++) begin
      in_a = {7'd0, pa[i]}; in_b = {7'd0, pb[i]};
      chk($sformatf("one_rdy%0d", i), in_rdy, 1);
      tick;
      chk($sformatf("one_vld%0d", i), vld, 1);
      chk($sformatf("one_last%0d", i), last, 1);
      chk($sformatf("one_a%0d", i), a, pa[i]);
      chk($sformatf("one_b%0d", i), b, pb[i]);
    end
    chk("one_rdy3", in_rdy, 1);
    in_vld = 0;
    tick;
    idle_chk("one_end");

    ta = 6'b011111; tb = 6'b010000; tl = 6'b101000;
    in_a = 8'hFF; in_b = 8'h00; in_last_idx = 3; in_vld = 1;
    tick;
    in_a = 8'h01; in_b = 8'h01; in_last_idx = 1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("trn_vld%0d", k), vld, 1);
      chk($sformatf("trn_a%0d", k), a, ta[k]);
      chk($sformatf("trn_b%0d", k), b, tb[k]);
      chk($sformatf("trn_last%0d", k), last, tl[k]);
      tick;
      if (k == 3) in_vld = 0;
    end
    idle_chk("trn_end");

    in_a = 8'hA5; in_b = 8'h3C; in_last_idx = 7; in_vld = 1;
    tick;
    in_vld = 0;
    tick; tick; tick;
    chk("mid_vld3", vld, 1);
    chk("mid_b3", b, 1);
    #2 rst = 0;
    #1 idle_chk("mid_rst");
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      idle_chk($sformatf("mid_after%0d", i));
    end

    in_a = 8'hA5; in_b = 8'h3C; in_last_idx = 7; in_vld = 1;
    tick;
    in_vld = 0;
    c = 0; sum = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("e2e_vld%0d", k), vld, 1);
      sum[k] = a ^ b ^ c;
      c = (a & b) | (c & (a ^ b));
      tick;
    end
    chk("e2e_sum", sum, 8'hE1);
    idle_chk("e2e_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
